// File: rtl/psram_async_ctrl_pkg.sv
// Shared types and defaults for the asynchronous-mode PSRAM controller.
// FSM state encoding, inactive strobe level and timing defaults live here.
package psram_async_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WSET,
        S_WPUL,
        S_WHLD,
        S_REC
    } state_t;

    localparam logic STROBE_OFF = 1'b1;

    localparam int unsigned DEF_AW      = 23;
    localparam int unsigned DEF_DW      = 16;
    localparam int unsigned DEF_RD_WAIT = 7;
    localparam int unsigned DEF_WR_WAIT = 6;
    localparam int unsigned DEF_TURN    = 1;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/psram_async_ctrl_if.sv
// Host-side request/completion port of the PSRAM controller.
interface psram_async_ctrl_if
    import psram_async_ctrl_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
);
    logic            req;
    logic            wr;
    logic [AW-1:0]   addr_in;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] be;
    logic            busy;
    logic            done;
    logic [DW-1:0]   rdata;

    modport master (
        output req, wr, addr_in, wdata, be,
        input  busy, done, rdata
    );

    modport slave (
        input  req, wr, addr_in, wdata, be,
        output busy, done, rdata
    );
endinterface

// File: rtl/psram_async_ctrl.sv
// Asynchronous-mode PSRAM controller: one host request at a time, programmable
// read access / write pulse / turnaround timing, all pin outputs from flops.
module psram_async_ctrl
    import psram_async_ctrl_pkg::*;
#(
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned RD_WAIT = DEF_RD_WAIT,
    parameter int unsigned WR_WAIT = DEF_WR_WAIT,
    parameter int unsigned TURN    = DEF_TURN
) (
    input  logic                clk,
    input  logic                clr,
    psram_async_ctrl_if.slave   host,
    output logic [AW-1:0]       mem_addr,
    inout  wire  [DW-1:0]       mem_data,
    output logic                mem_ce_n,
    output logic                mem_oe_n,
    output logic                mem_we_n,
    output logic                mem_ub_n,
    output logic                mem_lb_n,
    output logic                mem_adv_n,
    output logic                mem_clk,
    output logic                mem_cre
);

    localparam int unsigned CW = $clog2(max3(RD_WAIT, WR_WAIT, TURN) + 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_wdata;
    logic            r_dq_oe;
    logic            w_cnt_last;

    assign w_cnt_last = (r_cnt == CW'(1));

    assign mem_data  = r_dq_oe ? r_wdata : 'z;
    assign mem_adv_n = 1'b0;
    assign mem_clk   = 1'b0;
    assign mem_cre   = 1'b0;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_wdata    <= '0;
            r_dq_oe    <= 1'b0;
            host.busy  <= 1'b0;
            host.done  <= 1'b0;
            host.rdata <= '0;
            mem_addr   <= '0;
            mem_ce_n   <= STROBE_OFF;
            mem_oe_n   <= STROBE_OFF;
            mem_we_n   <= STROBE_OFF;
            mem_ub_n   <= STROBE_OFF;
            mem_lb_n   <= STROBE_OFF;
        end else begin
            host.done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (host.req) begin
                        host.busy <= 1'b1;
                        mem_addr  <= host.addr_in;
                        r_wdata   <= host.wdata;
                        mem_ub_n  <= (DW > 8) ? ~host.be[DW/8-1] : STROBE_OFF;
                        mem_lb_n  <= ~host.be[0];
                        mem_ce_n  <= 1'b0;
                        if (host.wr) begin
                            // DQ enable rises with WSET entry so data is set up before WE falls
                            r_dq_oe <= 1'b1;
                            r_state <= S_WSET;
                            r_cnt   <= CW'(1);
                        end else begin
                            mem_oe_n <= 1'b0;
                            r_state  <= S_RD;
                            r_cnt    <= CW'(RD_WAIT);
                        end
                    end
                end
                S_RD: begin
                    if (w_cnt_last) begin
                        host.rdata <= mem_data;
                        mem_oe_n   <= STROBE_OFF;
                        mem_ce_n   <= STROBE_OFF;
                        mem_ub_n   <= STROBE_OFF;
                        mem_lb_n   <= STROBE_OFF;
                        r_state    <= S_REC;
                        r_cnt      <= CW'(TURN);
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_WSET: begin
                    mem_we_n <= 1'b0;
                    r_state  <= S_WPUL;
                    r_cnt    <= CW'(WR_WAIT);
                end
                S_WPUL: begin
                    if (w_cnt_last) begin
                        mem_we_n <= STROBE_OFF;
                        r_state  <= S_WHLD;
                        r_cnt    <= CW'(1);
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_WHLD: begin
                    mem_ce_n <= STROBE_OFF;
                    mem_ub_n <= STROBE_OFF;
                    mem_lb_n <= STROBE_OFF;
                    r_dq_oe  <= 1'b0;
                    r_state  <= S_REC;
                    r_cnt    <= CW'(TURN);
                end
                S_REC: begin
                    if (w_cnt_last) begin
                        host.busy <= 1'b0;
                        host.done <= 1'b1;
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
